// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control decoder between decode and EX.
//   Accepts one {opcode,funct} per valid/ready transfer and presents the ALU
//   control word one cycle later. Multi-cycle ops (mult/multu/div/divu) hold
//   off new input while EX is occupied for MUL_CYCLES/DIV_CYCLES cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake for opcode/funct
//   opcode, funct         instruction [31:26] and [5:0]
//   out_valid/out_ready   output handshake for ctrl_bits/illegal/multi_cycle
//   ctrl_bits             ALU control word (6-bit code zero-extended)
//   illegal               undecodable opcode (qualified by out_valid)
//   multi_cycle           mult/div op (qualified by out_valid)
//   busy                  multi-cycle sequence in progress
//   done                  one-cycle pulse after a multi-cycle sequence ends
module alu_ctrl_seq #(
   parameter int          CTRL_W       = 6,
   parameter int          MUL_CYCLES   = 4,
   parameter int          DIV_CYCLES   = 32,
   parameter logic [5:0]  ILLEGAL_CODE = 6'b111111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] ctrl_bits,
   output logic              illegal,
   output logic              multi_cycle,
   output logic              busy,
   output logic              done
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_FULL,
      S_BUSY
   } state_t;

   state_t           state, state_nx;
   logic [5:0]       ctrl_r;
   logic             ill_r;
   logic             mc_r;
   logic             div_r;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             done_r, done_nx;

   logic [5:0]       dec_code;
   logic             dec_illegal;
   logic             dec_mul;
   logic             dec_div;
   logic             accept;

   // Combinational decode of the presented instruction.
   always_comb begin
      dec_code    = '0;
      dec_illegal = 1'b0;
      case (opcode)
         6'b000000,
         6'b000001: dec_code = funct;
         6'b001000: dec_code = 6'b100000;
         6'b001001: dec_code = 6'b100001;
         6'b001100: dec_code = 6'b100100;
         6'b001101: dec_code = 6'b100101;
         6'b001010: dec_code = 6'b101010;
         6'b001011: dec_code = 6'b101011;
         6'b001110: dec_code = 6'b100110;
         6'b100000,
         6'b100011,
         6'b101000,
         6'b101011: dec_code = 6'b100001;
         6'b001111: dec_code = 6'b111000;
         6'b000100: dec_code = 6'b110000;
         6'b000101: dec_code = 6'b110001;
         6'b000111: dec_code = 6'b110010;
         6'b000110: dec_code = 6'b110011;
         default: begin
            dec_code    = ILLEGAL_CODE;
            dec_illegal = 1'b1;
         end
      endcase
      // mult/multu = 01100x, div/divu = 01101x
      dec_mul = (opcode == 6'b000000) && (funct[5:1] == 5'b01100);
      dec_div = (opcode == 6'b000000) && (funct[5:1] == 5'b01101);
   end

   // Next-state and handshake logic.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      in_ready = 1'b0;
      case (state)
         S_EMPTY: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_FULL;
         end
         S_FULL: begin
            if (out_ready) begin
               if (mc_r) begin
                  state_nx = S_BUSY;
                  cnt_nx   = div_r ? DIV_LOAD : MUL_LOAD;
               end else begin
                  // Hand-off and refill in the same cycle keeps one op/cycle.
                  in_ready = 1'b1;
                  state_nx = in_valid ? S_FULL : S_EMPTY;
               end
            end
         end
         S_BUSY: begin
            if (cnt == '0) begin
               state_nx = S_EMPTY;
               done_nx  = 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = S_EMPTY;
      endcase
      accept = in_valid && in_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_EMPTY;
         ctrl_r <= '0;
         ill_r  <= 1'b0;
         mc_r   <= 1'b0;
         div_r  <= 1'b0;
         cnt    <= '0;
         done_r <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         done_r <= done_nx;
         if (accept) begin
            ctrl_r <= dec_code;
            ill_r  <= dec_illegal;
            mc_r   <= dec_mul || dec_div;
            div_r  <= dec_div;
         end
      end
   end

   assign out_valid   = (state == S_FULL);
   assign busy        = (state == S_BUSY);
   assign done        = done_r;
   assign ctrl_bits   = CTRL_W'(ctrl_r);
   assign illegal     = ill_r;
   assign multi_cycle = mc_r;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

   localparam int CTRL_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] ctrl_bits;
   logic              illegal;
   logic              multi_cycle;
   logic              busy;
   logic              done;

   alu_ctrl_seq #(
      .CTRL_W      (CTRL_W),
      .MUL_CYCLES  (4),
      .DIV_CYCLES  (32),
      .ILLEGAL_CODE(6'b111111)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .funct      (funct),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ctrl_bits  (ctrl_bits),
      .illegal    (illegal),
      .multi_cycle(multi_cycle),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              ill;
      logic              mc;
   } word_t;

   word_t exp_q[$];
   word_t obs_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   // Reference decode, written straight from the opcode table.
   function automatic word_t model(input logic [5:0] op, input logic [5:0] fn);
      word_t w;
      w.ill  = 1'b0;
      w.mc   = (op == 6'd0) && (fn == 6'h18 || fn == 6'h19 || fn == 6'h1A || fn == 6'h1B);
      w.ctrl = 8'h00;
      case (op)
         6'd0, 6'd1:                w.ctrl = {2'b00, fn};
         6'd8:                      w.ctrl = 8'h20;
         6'd9:                      w.ctrl = 8'h21;
         6'd12:                     w.ctrl = 8'h24;
         6'd13:                     w.ctrl = 8'h25;
         6'd10:                     w.ctrl = 8'h2A;
         6'd11:                     w.ctrl = 8'h2B;
         6'd14:                     w.ctrl = 8'h26;
         6'd32, 6'd35, 6'd40, 6'd43: w.ctrl = 8'h21;
         6'd15:                     w.ctrl = 8'h38;
         6'd4:                      w.ctrl = 8'h30;
         6'd5:                      w.ctrl = 8'h31;
         6'd7:                      w.ctrl = 8'h32;
         6'd6:                      w.ctrl = 8'h33;
         default: begin
            w.ctrl = 8'h3F;
            w.ill  = 1'b1;
         end
      endcase
      return w;
   endfunction

   // Scoreboard feed: expectation on accept, observation on hand-off.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) exp_q.push_back(model(opcode, funct));
      if (rst_n && out_valid && out_ready) obs_q.push_back({ctrl_bits, illegal, multi_cycle});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, want finish");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; funct = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_cmp++;
      if ({out_valid, busy, done, illegal, multi_cycle} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: got ov=%b busy=%b done=%b ill=%b mc=%b want all 0",
                  out_valid, busy, done, illegal, multi_cycle);
      end
      n_cmp++;
      if (ctrl_bits !== '0) begin
         n_err++; $display("FAIL reset_ctrl: got %h want 00", ctrl_bits);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_addi();
      word_t o, e;
      @(posedge clk); #1;
      opcode = 6'b001000; funct = 6'd0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || ctrl_bits !== 8'h20) begin
         n_err++; $display("FAIL addi_latency: got ov=%b ctrl=%h want ov=1 ctrl=20", out_valid, ctrl_bits);
      end
      @(posedge clk); #1;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL addi_word: got %h/%b/%b want %h/%b/%b", o.ctrl, o.ill, o.mc, e.ctrl, e.ill, e.mc);
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++; $display("FAIL addi_count: got obs=%0d exp=%0d left want 0", obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_stream();
      logic [5:0] ops[3] = '{6'd0, 6'd0, 6'd13};
      logic [5:0] fns[3] = '{6'h20, 6'h22, 6'h00};
      logic [7:0] want[3] = '{8'h20, 8'h22, 8'h25};
      int         seen_ov;
      word_t      o, e;
      seen_ov = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         opcode = ops[i]; funct = fns[i]; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk); #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready);
         end
         if (out_valid) seen_ov++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #1;
      if (out_valid) seen_ov++;
      n_cmp++;
      if (seen_ov != 3) begin
         n_err++; $display("FAIL stream_consecutive: got %0d valid cycles want 3", seen_ov);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
         if (o !== e || o.ctrl !== want[i]) begin
            n_err++; $display("FAIL stream_word[%0d]: got %h want %h", i, o.ctrl, want[i]);
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++; $display("FAIL stream_count: got obs=%0d exp=%0d left want 0", obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_backpressure();
      word_t o, e;
      @(posedge clk); #1;
      opcode = 6'b100011; funct = 6'd5; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      // next op offered and held while blocked
      opcode = 6'b001101; funct = 6'd0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || ctrl_bits !== 8'h21 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_hold[%0d]: got ov=%b ctrl=%h rdy=%b want ov=1 ctrl=21 rdy=0",
                              i, out_valid, ctrl_bits, in_ready);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL bp_word: got %h/%b/%b want %h/%b/%b", o.ctrl, o.ill, o.mc, e.ctrl, e.ill, e.mc);
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++; $display("FAIL bp_count: got obs=%0d exp=%0d left want 0", obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_multi(input string name, input logic [5:0] fn, input int ncyc);
      int    busy_cnt, done_cnt, bad, rdy_bad;
      word_t o, e;
      busy_cnt = 0; done_cnt = 0; bad = 0; rdy_bad = 0;
      @(posedge clk); #1;
      opcode = 6'd0; funct = fn; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < ncyc + 10; i++) begin
         @(negedge clk); #1;
         if (busy) busy_cnt++;
         if (busy && (out_valid || done || in_ready)) bad++;
         if (done) begin
            done_cnt++;
            if (in_ready !== 1'b1) rdy_bad++;
         end
      end
      n_cmp++;
      if (busy_cnt != ncyc) begin
         n_err++; $display("FAIL %s_busy_len: got %0d want %0d", name, busy_cnt, ncyc);
      end
      n_cmp++;
      if (done_cnt != 1) begin
         n_err++; $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt);
      end
      n_cmp++;
      if (bad != 0 || rdy_bad != 0) begin
         n_err++; $display("FAIL %s_flags: got %0d busy overlaps, %0d not-ready at done want 0/0", name, bad, rdy_bad);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL %s_word: got %h/%b/%b want %h/%b/%b", name, o.ctrl, o.ill, o.mc, e.ctrl, e.ill, e.mc);
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++; $display("FAIL %s_count: got obs=%0d exp=%0d left want 0", name, obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_illegal();
      word_t o, e;
      @(posedge clk); #1;
      opcode = 6'b111111; funct = 6'd0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      opcode = 6'b001001;
      @(negedge clk); #1;
      n_cmp++;
      if (illegal !== 1'b1 || ctrl_bits !== 8'h3F) begin
         n_err++; $display("FAIL illegal_flag: got ill=%b ctrl=%h want ill=1 ctrl=3f", illegal, ctrl_bits);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL illegal_word: got %h/%b/%b want %h/%b/%b", o.ctrl, o.ill, o.mc, e.ctrl, e.ill, e.mc);
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++; $display("FAIL illegal_count: got obs=%0d exp=%0d left want 0", obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_reset_busy();
      int stray;
      stray = 0;
      @(posedge clk); #1;
      opcode = 6'd0; funct = 6'b011000; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); #1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL rstbusy_entered: got busy=%b want 1", busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL rstbusy_state: got busy=%b ov=%b done=%b rdy=%b want 0/0/0/1",
                           busy, out_valid, done, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         if (done || busy) stray++;
      end
      n_cmp++;
      if (stray != 0) begin
         n_err++; $display("FAIL rstbusy_no_done: got %0d busy/done cycles want 0", stray);
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      logic [5:0] ops[21] = '{6'd0, 6'd1, 6'd8, 6'd9, 6'd12, 6'd13, 6'd10, 6'd11, 6'd14, 6'd32,
                              6'd35, 6'd40, 6'd43, 6'd15, 6'd4, 6'd5, 6'd7, 6'd6, 6'd63, 6'd2, 6'd17};
      logic       acc;
      int         total;
      word_t      o, e;
      acc = 1'b0; total = 0;
      in_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            opcode   = ops[$urandom_range(0, 20)];
            funct    = 6'($urandom_range(0, 63));
            if (opcode == 6'd0 && funct[5:2] == 4'b0110) funct = 6'h21;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk); #1;
         acc = in_valid && in_ready;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++; total++;
         if (o !== e) begin
            n_err++; $display("FAIL random_word[%0d]: got %h/%b/%b want %h/%b/%b", total, o.ctrl, o.ill, o.mc, e.ctrl, e.ill, e.mc);
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0 || total == 0) begin
         n_err++; $display("FAIL random_count: got obs=%0d exp=%0d left, %0d matched want 0/0/>0",
                           obs_q.size(), exp_q.size(), total);
         obs_q.delete(); exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_stream();
      test_backpressure();
      test_multi("div", 6'b011010, 32);
      test_multi("mult", 6'b011000, 4);
      test_illegal();
      test_reset_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
